fp_mult_pipe: RTL and testbench
===============================

// Module: fp_mult_pipe
// PURPOSE
//  Parametrised, multi-lane IEEE-754 single-precision multiplier pipeline in soft logic.
//  Generalises the fixed single-lane hard-DSP sp_mult wrapper with:
//   - LANES parallel lanes sharing one valid/stall control;
//   - configurable LATENCY;
//   - a per-lane negate option;
//   - a sideband TAG carried alongside the data.
//  Sits in the force-evaluation datapath: r2 * coefficient scaling, with the TAG carrying the particle ID.
// PARAMETERS
//  LANES    1  number of independent 32-bit multiply lanes
//  LATENCY  4  in_valid -> out_valid cycles when ena=1; legal range 3..8
//  TAG_W    8  width of sideband tag passed through unchanged
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  ena        in   1          pipeline advance; 0 freezes every stage
//  in_valid   in   1          operand set valid this cycle (sampled only when ena=1)
//  in_ay      in   32*LANES   operand A, lane i at [32i+31:32i]
//  in_az      in   32*LANES   operand B, same packing
//  in_neg     in   LANES      1: result sign inverted for that lane
//  in_tag     in   TAG_W      sideband tag
//  out_valid  out  1          result/tag valid
//  result     out  32*LANES   product per lane
//  out_tag    out  TAG_W      tag matching result
// BEHAVIOUR
//  Reset: on a rst=1 edge, all valid bits and all stage registers are cleared.
//   - out_valid=0, result=0, out_tag=0; this takes effect even when ena=0.
//   - rst mid-flight discards all in-flight operations.
//  Stall: ena=0 holds every register, valid bits included. Outputs stay stable and nothing is lost or duplicated.
//  Latency: exactly LATENCY enabled cycles. Stages, in order:
//   - S1: unpack, special-case classify.
//   - S2: 24x24 mantissa product, exponent sum.
//   - S3: normalise, round, pack.
//   - LATENCY-3 extra delay stages on the output.
//  Throughput: one operand set per enabled cycle; no backpressure beyond ena.
//  Data/tag are don't-care-held when valid=0: registers load regardless of valid. Bench checks result only when out_valid=1.
//  Arithmetic, per lane:
//   - sign = sA ^ sB ^ neg.
//   - Exponent: eA+eB-127, held in a 10-bit signed intermediate.
//   - 48-bit product; if bit47 is set, shift right 1 and exp+1.
//   - Round-to-nearest-even on guard/sticky. A mantissa carry-out from rounding increments exp.
//  Denormals: any denormal input is treated as zero.
//   - A result below 2^-126 after rounding flushes to signed zero {sign,31'b0}.
//  Overflow: final exp >= 255 gives signed infinity {sign,8'hFF,23'b0}.
//  Specials, in priority order:
//   - any NaN input -> 32'h7FC00000;
//   - Inf*0 -> 32'h7FC00000;
//   - Inf*x -> signed Inf;
//   - 0*x -> signed zero.
//  Neg applies to Inf and zero results. It does not apply to the canonical NaN.
//  Lanes are independent: a special value in one lane does not affect the others.
//  LATENCY outside 3..8: elaboration error via generate-time check.
// TESTING
//  1 lane0 0x40000000*0x40400000 (2*3) -> 0x40C00000; out_valid exactly 4 cycles later.
//  2 0x3F800001*0x3F800001 -> 0x3F800002 (RNE drops 2^-46); 0x3FC00000*0x3FC00000 -> 0x40100000.
//  3 Overflow and flush:
//     - 0x7F000000*0x40000000 -> 0x7F800000;
//     - 0x00800000*0x3F000000 -> 0x00000000;
//     - 0x00000001*0x3F800000 -> 0x00000000.
//  4 Specials and negate:
//     - 0x7F800000*0x00000000 -> 0x7FC00000;
//     - 0x7FC00001*0x3F800000 -> 0x7FC00000;
//     - in_neg=1, 0x40000000*0x40000000 -> 0xC0800000.
//  5 Streaming with LANES=4: back-to-back in_valid with tags 1..10, ena=0 for 3 cycles mid-stream.
//     - Required: 10 outputs in order, tags 1..10, none dropped or duplicated.
//     - Required: outputs frozen while ena=0.
//  6 rst=1 for one cycle with 3 operations in flight and ena=0 -> next cycle out_valid=0, result=0; no stale outputs later.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Multi-lane IEEE-754 single-precision multiplier pipeline.
// Stage 1 unpacks and classifies, stage 2 forms the 48-bit mantissa product,
// stage 3 normalises, rounds to nearest-even and packs, then LATENCY-3 plain
// delay stages follow. Denormal inputs are treated as zero and tiny results
// flush to signed zero. A single ena advances or freezes the whole pipeline.
module fp_mult_pipe #(
    parameter int unsigned LANES   = 1,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_valid,
    input  logic [32*LANES-1:0]   in_ay,
    input  logic [32*LANES-1:0]   in_az,
    input  logic [LANES-1:0]      in_neg,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    output logic [32*LANES-1:0]   result,
    output logic [TAG_W-1:0]      out_tag
);

    // Stage-3 register plus the extra output delay stages form one chain.
    localparam int unsigned DLY = (LATENCY >= 3) ? LATENCY - 2 : 1;

    if (LATENCY < 3 || LATENCY > 8) begin : g_latency_check
        $error("fp_mult_pipe: LATENCY must be in the range 3..8");
    end

    typedef enum logic [1:0] {
        ClsNorm,
        ClsNan,
        ClsInf,
        ClsZero
    } cls_e;

    // Special-case class of a product, in NaN > Inf*0 > Inf > zero priority.
    function automatic cls_e classify(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        cls_e cls;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        // Exponent zero covers both true zero and denormals.
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan) begin
            cls = ClsNan;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            cls = ClsNan;
        end else if (a_inf || b_inf) begin
            cls = ClsInf;
        end else if (a_zero || b_zero) begin
            cls = ClsZero;
        end else begin
            cls = ClsNorm;
        end
        return cls;
    endfunction

    // Normalise, round to nearest-even, detect overflow/underflow and pack.
    function automatic logic [31:0] round_pack(input logic              sign,
                                               input logic signed [9:0] exp_in,
                                               input logic [47:0]       prod,
                                               input cls_e              cls);
        logic [23:0]        mant;
        logic               guard;
        logic               sticky;
        logic               rnd;
        logic [24:0]        mant_r;
        logic signed [9:0]  exp_n;
        logic [22:0]        frac;
        logic [31:0]        res;
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_in + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd};
        // Rounding carry-out leaves 1.000..0 one binade up.
        if (mant_r[24]) begin
            exp_n = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end else begin
            frac  = mant_r[22:0];
        end
        case (cls)
            ClsNan:  res = 32'h7FC0_0000;
            ClsInf:  res = {sign, 8'hFF, 23'd0};
            ClsZero: res = {sign, 31'd0};
            default: begin
                if (exp_n >= 10'sd255) begin
                    res = {sign, 8'hFF, 23'd0};
                end else if (exp_n <= 10'sd0) begin
                    res = {sign, 31'd0};
                end else begin
                    res = {sign, exp_n[7:0], frac};
                end
            end
        endcase
        return res;
    endfunction

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    logic                 s1_sign_q [LANES];
    logic                 s1_sign_d [LANES];
    logic signed [9:0]    s1_exp_q  [LANES];
    logic signed [9:0]    s1_exp_d  [LANES];
    logic [23:0]          s1_ma_q   [LANES];
    logic [23:0]          s1_ma_d   [LANES];
    logic [23:0]          s1_mb_q   [LANES];
    logic [23:0]          s1_mb_d   [LANES];
    cls_e                 s1_cls_q  [LANES];
    cls_e                 s1_cls_d  [LANES];

    // Stage 2 state
    logic                 s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;
    logic                 s2_sign_q [LANES];
    logic                 s2_sign_d [LANES];
    logic signed [9:0]    s2_exp_q  [LANES];
    logic signed [9:0]    s2_exp_d  [LANES];
    logic [47:0]          s2_prod_q [LANES];
    logic [47:0]          s2_prod_d [LANES];
    cls_e                 s2_cls_q  [LANES];
    cls_e                 s2_cls_d  [LANES];

    // Stage 3 and output delay chain; entry DLY-1 drives the ports.
    logic                 dly_valid_q [DLY];
    logic                 dly_valid_d [DLY];
    logic [32*LANES-1:0]  dly_res_q   [DLY];
    logic [32*LANES-1:0]  dly_res_d   [DLY];
    logic [TAG_W-1:0]     dly_tag_q   [DLY];
    logic [TAG_W-1:0]     dly_tag_d   [DLY];

    // Stage 1: unpack operands, compute sign and biased exponent sum, classify.
    always_comb begin
        s1_valid_d = in_valid;
        s1_tag_d   = in_tag;
        for (int unsigned i = 0; i < LANES; i++) begin
            s1_sign_d[i] = in_ay[32*i+31] ^ in_az[32*i+31] ^ in_neg[i];
            s1_exp_d[i]  = $signed({2'b00, in_ay[32*i+23 +: 8]})
                         + $signed({2'b00, in_az[32*i+23 +: 8]}) - 10'sd127;
            s1_ma_d[i]   = {1'b1, in_ay[32*i +: 23]};
            s1_mb_d[i]   = {1'b1, in_az[32*i +: 23]};
            s1_cls_d[i]  = classify(in_ay[32*i +: 32], in_az[32*i +: 32]);
        end
    end

    // Stage 2: full 24x24 mantissa product; other fields pass through.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            s2_sign_d[i] = s1_sign_q[i];
            s2_exp_d[i]  = s1_exp_q[i];
            s2_prod_d[i] = {24'd0, s1_ma_q[i]} * {24'd0, s1_mb_q[i]};
            s2_cls_d[i]  = s1_cls_q[i];
        end
    end

    // Stage 3 round/pack into the head of the delay chain, then shift along.
    always_comb begin
        dly_valid_d[0] = s2_valid_q;
        dly_tag_d[0]   = s2_tag_q;
        dly_res_d[0]   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            dly_res_d[0][32*i +: 32] = round_pack(s2_sign_q[i], s2_exp_q[i],
                                                  s2_prod_q[i], s2_cls_q[i]);
        end
        for (int unsigned k = 1; k < DLY; k++) begin
            dly_valid_d[k] = dly_valid_q[k-1];
            dly_tag_d[k]   = dly_tag_q[k-1];
            dly_res_d[k]   = dly_res_q[k-1];
        end
    end

    // All stage registers: reset wins over ena, ena=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_sign_q[i] <= 1'b0;
                s1_exp_q[i]  <= '0;
                s1_ma_q[i]   <= '0;
                s1_mb_q[i]   <= '0;
                s1_cls_q[i]  <= ClsNorm;
                s2_sign_q[i] <= 1'b0;
                s2_exp_q[i]  <= '0;
                s2_prod_q[i] <= '0;
                s2_cls_q[i]  <= ClsNorm;
            end
            for (int unsigned k = 0; k < DLY; k++) begin
                dly_valid_q[k] <= 1'b0;
                dly_tag_q[k]   <= '0;
                dly_res_q[k]   <= '0;
            end
        end else if (ena) begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_sign_q[i] <= s1_sign_d[i];
                s1_exp_q[i]  <= s1_exp_d[i];
                s1_ma_q[i]   <= s1_ma_d[i];
                s1_mb_q[i]   <= s1_mb_d[i];
                s1_cls_q[i]  <= s1_cls_d[i];
                s2_sign_q[i] <= s2_sign_d[i];
                s2_exp_q[i]  <= s2_exp_d[i];
                s2_prod_q[i] <= s2_prod_d[i];
                s2_cls_q[i]  <= s2_cls_d[i];
            end
            for (int unsigned k = 0; k < DLY; k++) begin
                dly_valid_q[k] <= dly_valid_d[k];
                dly_tag_q[k]   <= dly_tag_d[k];
                dly_res_q[k]   <= dly_res_d[k];
            end
        end
    end

    assign out_valid = dly_valid_q[DLY-1];
    assign result    = dly_res_q[DLY-1];
    assign out_tag   = dly_tag_q[DLY-1];

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (4 lanes, latency 4).
module tb_fp_mult_pipe;

    localparam int unsigned LANES   = 4;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned TAG_W   = 8;
    localparam int          NV      = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ena;
    logic                 in_valid;
    logic [32*LANES-1:0]  in_ay;
    logic [32*LANES-1:0]  in_az;
    logic [LANES-1:0]     in_neg;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic [32*LANES-1:0]  result;
    logic [TAG_W-1:0]     out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        neg;
        logic [31:0] y;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    fp_mult_pipe #(
        .LANES   (LANES),
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ay     (in_ay),
        .in_az     (in_az),
        .in_neg    (in_neg),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .result    (result),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input int lane, input vec_t v);
        in_ay[32*lane +: 32] = v.a;
        in_az[32*lane +: 32] = v.b;
        in_neg[lane]         = v.neg;
        if (idx < 0) begin
            in_neg[lane] = v.neg;
        end
    endtask

    logic [127:0]      exp_res;
    logic [TAG_W-1:0]  exp_tag_q [$];
    logic [127:0]      exp_res_q [$];
    logic [31:0]       op_a;
    logic              last_v;
    logic [TAG_W-1:0]  last_tag;
    logic [127:0]      last_res;
    int                issued;
    int                got;

    initial begin
        vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40C0_0000};
        vecs[1]  = '{32'h3F80_0001, 32'h3F80_0001, 1'b0, 32'h3F80_0002};
        vecs[2]  = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4010_0000};
        vecs[3]  = '{32'h7F00_0000, 32'h4000_0000, 1'b0, 32'h7F80_0000};
        vecs[4]  = '{32'h0080_0000, 32'h3F00_0000, 1'b0, 32'h0000_0000};
        vecs[5]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h0000_0000};
        vecs[6]  = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000};
        vecs[7]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000};
        vecs[8]  = '{32'h4000_0000, 32'h4000_0000, 1'b1, 32'hC080_0000};
        vecs[9]  = '{32'h7F80_0000, 32'hC000_0000, 1'b0, 32'hFF80_0000};
        vecs[10] = '{32'h0000_0000, 32'hBF80_0000, 1'b0, 32'h8000_0000};
        vecs[11] = '{32'h7FC0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000};
        vecs[12] = '{32'h3FC0_0001, 32'h3FC0_0000, 1'b0, 32'h4010_0001};
        vecs[13] = '{32'h3F80_0001, 32'h3FC0_0000, 1'b0, 32'h3FC0_0002};
        vecs[14] = '{32'h3F80_0003, 32'h3FC0_0000, 1'b0, 32'h3FC0_0004};
        vecs[15] = '{32'h3FFF_FFFE, 32'h3F80_0001, 1'b0, 32'h4000_0000};
        vecs[16] = '{32'h7F7F_FFFE, 32'h3F80_0001, 1'b0, 32'h7F80_0000};
        vecs[17] = '{32'h3F80_0000, 32'h0080_0000, 1'b1, 32'h8080_0000};
        vecs[18] = '{32'hBF80_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000};
        vecs[19] = '{32'h8000_0000, 32'h7F80_0000, 1'b0, 32'h7FC0_0000};

        rst      = 1'b1;
        ena      = 1'b1;
        in_valid = 1'b0;
        in_ay    = '0;
        in_az    = '0;
        in_neg   = '0;
        in_tag   = '0;
        step();
        step();
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_result", result, 128'd0);
        check("reset_tag", 128'(out_tag), 128'd0);
        rst = 1'b0;
        step();

        // Table vectors: lane l carries vector (k+l) mod NV so each lane sees every case.
        for (int k = 0; k < NV; k++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                set_vec(k, l, vecs[(k + l) % NV]);
                exp_res[32*l +: 32] = vecs[(k + l) % NV].y;
            end
            in_tag   = 8'(k + 8'h40);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
            check($sformatf("lat_early_%0d", k), 128'(out_valid), 128'd0);
            step();
            check($sformatf("lat_valid_%0d", k), 128'(out_valid), 128'd1);
            check($sformatf("vec_result_%0d", k), result, exp_res);
            check($sformatf("vec_tag_%0d", k), 128'(out_tag), 128'(8'(k + 8'h40)));
            step();
        end

        // Streaming 10 ops with a 3-cycle stall in the middle.
        issued   = 0;
        got      = 0;
        last_v   = out_valid;
        last_tag = out_tag;
        last_res = result;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ena = !(cyc >= 6 && cyc < 9);
            if (ena) begin
                if (issued < 10) begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        op_a = {1'b0, 8'(127 + l), 23'(issued * 7 + l)};
                        in_ay[32*l +: 32] = op_a;
                        in_az[32*l +: 32] = 32'h3F80_0000;
                        in_neg[l]         = (l == 3);
                        exp_res[32*l +: 32] = {(l == 3), op_a[30:0]};
                    end
                    in_tag   = 8'(issued + 1);
                    in_valid = 1'b1;
                    exp_tag_q.push_back(8'(issued + 1));
                    exp_res_q.push_back(exp_res);
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            if (ena) begin
                if (out_valid) begin
                    if (exp_tag_q.size() == 0) begin
                        check($sformatf("stream_extra_c%0d", cyc), 128'(out_tag), 128'd0);
                    end else begin
                        check($sformatf("stream_tag_c%0d", cyc), 128'(out_tag),
                              128'(exp_tag_q.pop_front()));
                        check($sformatf("stream_res_c%0d", cyc), result, exp_res_q.pop_front());
                        got++;
                    end
                end
            end else begin
                check($sformatf("stall_valid_c%0d", cyc), 128'(out_valid), 128'(last_v));
                check($sformatf("stall_tag_c%0d", cyc), 128'(out_tag), 128'(last_tag));
                check($sformatf("stall_res_c%0d", cyc), result, last_res);
                check($sformatf("stall_busy_c%0d", cyc), 128'(out_valid), 128'd1);
            end
            last_v   = out_valid;
            last_tag = out_tag;
            last_res = result;
        end
        check("stream_count", 128'(got), 128'd10);
        ena      = 1'b1;
        in_valid = 1'b0;
        step();

        // Reset while stalled with operations in flight.
        for (int l = 0; l < int'(LANES); l++) begin
            set_vec(0, l, vecs[0]);
        end
        for (int n = 0; n < 4; n++) begin
            in_tag   = 8'(8'hA1 + n);
            in_valid = 1'b1;
            step();
        end
        check("prerst_valid", 128'(out_valid), 128'd1);
        check("prerst_tag", 128'(out_tag), 128'hA1);
        ena = 1'b0;
        rst = 1'b1;
        step();
        check("rst_stall_valid", 128'(out_valid), 128'd0);
        check("rst_stall_result", result, 128'd0);
        check("rst_stall_tag", 128'(out_tag), 128'd0);
        rst      = 1'b0;
        ena      = 1'b1;
        in_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            check($sformatf("post_rst_valid_%0d", n), 128'(out_valid), 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
